// File: rtl/clock_display_driver.sv
// Six-digit multiplexed seven-segment driver for an HH.MM.SS clock.
// A scan divider steps through the six digits; once per frame the binary
// hour/minute/second inputs are snapshotted and converted to BCD by a
// bit-serial double-dabble engine, and the six displayed digits are replaced
// together when the conversion finishes. Error (led) and bell (ring) inputs
// override the glyphs and the digit enables respectively.
//
// Handshake note: this block has no valid/ready interfaces; the inputs are
// free-running levels sampled every cycle, and the only internal
// "transaction" is the frame-start -> CONV -> DONE conversion sequence.
module clock_display_driver #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic       ring,
  input  logic       led,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  // Digit value 4'hF marks a dashed digit (field above 99).
  localparam logic [3:0] DIG_DASH = 4'hF;

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_t;

  conv_state_t state_q, state_d;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [2:0]    digit_idx;
  logic          frame_start;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [2:0]    bit_cnt;
  // Shift registers: {hundreds, tens, ones, binary}; BCD lives in [19:8].
  logic [19:0]   h_sr, m_sr, s_sr;
  logic          h_over, m_over, s_over;

  // Displayed digits: 0 = second ones ... 5 = hour tens.
  logic [3:0]    dig0, dig1, dig2, dig3, dig4, dig5;
  logic [3:0]    cur_dig;

  // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift.
  function automatic logic [19:0] dd_step(input logic [19:0] x);
    logic [19:0] y;
    y = x;
    for (int k = 0; k < 3; k++) begin
      if (y[8+4*k +: 4] >= 4'd5) y[8+4*k +: 4] = y[8+4*k +: 4] + 4'd3;
    end
    return {y[18:0], 1'b0};
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one digit value.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:     s = 7'b1000000;
      4'd1:     s = 7'b1111001;
      4'd2:     s = 7'b0100100;
      4'd3:     s = 7'b0110000;
      4'd4:     s = 7'b0011001;
      4'd5:     s = 7'b0010010;
      4'd6:     s = 7'b0000010;
      4'd7:     s = 7'b1111000;
      4'd8:     s = 7'b0000000;
      4'd9:     s = 7'b0010000;
      DIG_DASH: s = SEG_DASH;
      default:  s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign tick        = (tick_cnt == TICK_LAST);
  assign frame_start = tick && (digit_idx == 3'd5);

  // Scan divider and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      digit_idx <= 3'd0;
    end else if (tick) begin
      tick_cnt  <= '0;
      digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      tick_cnt  <= tick_cnt + 1'b1;
    end
  end

  // Blink timer: counts scan ticks while the bell rings, cleared when it stops.
  always_ff @(posedge clk) begin
    if (rst || !ring) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 1'b1;
      end
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Conversion FSM next state: 8 CONV cycles, one DONE cycle, back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_start) state_d = ST_CONV;
      ST_CONV: if (bit_cnt == 3'd7) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Conversion datapath: snapshot at frame start, shift in CONV, commit in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      h_sr    <= '0;
      m_sr    <= '0;
      s_sr    <= '0;
      h_over  <= 1'b0;
      m_over  <= 1'b0;
      s_over  <= 1'b0;
      dig0    <= 4'd0;
      dig1    <= 4'd0;
      dig2    <= 4'd0;
      dig3    <= 4'd0;
      dig4    <= 4'd0;
      dig5    <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            bit_cnt <= 3'd0;
            h_sr    <= {12'd0, hour};
            m_sr    <= {12'd0, minute};
            s_sr    <= {12'd0, second};
            h_over  <= (hour   > 8'd99);
            m_over  <= (minute > 8'd99);
            s_over  <= (second > 8'd99);
          end
        end
        ST_CONV: begin
          bit_cnt <= bit_cnt + 3'd1;
          h_sr    <= dd_step(h_sr);
          m_sr    <= dd_step(m_sr);
          s_sr    <= dd_step(s_sr);
        end
        ST_DONE: begin
          dig0 <= s_over ? DIG_DASH : s_sr[11:8];
          dig1 <= s_over ? DIG_DASH : s_sr[15:12];
          dig2 <= m_over ? DIG_DASH : m_sr[11:8];
          dig3 <= m_over ? DIG_DASH : m_sr[15:12];
          dig4 <= h_over ? DIG_DASH : h_sr[11:8];
          dig5 <= h_over ? DIG_DASH : h_sr[15:12];
        end
        default: ;
      endcase
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur_dig = 4'd0;
    case (digit_idx)
      3'd0:    cur_dig = dig0;
      3'd1:    cur_dig = dig1;
      3'd2:    cur_dig = dig2;
      3'd3:    cur_dig = dig3;
      3'd4:    cur_dig = dig4;
      3'd5:    cur_dig = dig5;
      default: cur_dig = 4'd0;
    endcase
  end

  // Registered outputs; led and ring are used directly for 1-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 6'b111111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= (ring && blink_phase) ? 6'b111111 : ~(6'd1 << digit_idx);
      seg <= led ? SEG_E : seg_code(cur_dig);
      dp  <= led ? 1'b1 : !((digit_idx == 3'd2) || (digit_idx == 3'd4));
    end
  end

endmodule

// File: tb/tb_clock_display_driver.sv
// Self-checking bench for clock_display_driver with SCAN_DIV=16, BLINK_TICKS=2.
// The reference model tracks time as an edge count since reset and derives
// scan position, blink phase and displayed digits arithmetically.
module tb_clock_display_driver;

  localparam int SD = 16;
  localparam int BT = 2;
  localparam int FRAME = 6 * SD;

  logic       clk;
  logic       rst;
  logic [7:0] hour, minute, second;
  logic       ring, led;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  clock_display_driver #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .hour(hour), .minute(minute), .second(second),
    .ring(ring), .led(led), .seg(seg), .dp(dp), .an(an)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state.
  typedef struct { int due; int h; int m; int s; } pend_t;
  pend_t pq[$];
  int n;            // edges since reset release
  int ring_ticks;   // ticks seen during the current ring episode
  int mdig[6];      // displayed digit values, 10 = dash
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      10: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic set_field(input int v, input int hi, input int lo);
    if (v > 99) begin
      mdig[hi] = 10; mdig[lo] = 10;
    end else begin
      mdig[hi] = v / 10; mdig[lo] = v % 10;
    end
  endtask

  // Advance the model across one clock edge with the pre-edge inputs.
  task automatic model_edge(input bit r, input bit l, input bit rg,
                            input int h, input int m, input int s);
    int e, idx, phase;
    bit tick;
    if (r) begin
      n = 0; ring_ticks = 0; pq.delete();
      for (int i = 0; i < 6; i++) mdig[i] = 0;
      exp_an = 6'b111111; exp_seg = 7'b1111111; exp_dp = 1'b1;
      return;
    end
    e     = n + 1;
    idx   = (n / SD) % 6;
    tick  = ((n % SD) == SD - 1);
    phase = (ring_ticks / BT) % 2;
    exp_an  = (rg && phase == 1) ? 6'b111111 : ~(6'd1 << idx);
    exp_seg = l ? 7'b0000110 : glyph(mdig[idx]);
    exp_dp  = l ? 1'b1 : ((idx == 2 || idx == 4) ? 1'b0 : 1'b1);
    if (rg) begin
      if (tick) ring_ticks++;
    end else begin
      ring_ticks = 0;
    end
    if (tick && idx == 5) pq.push_back('{due: e + 9, h: h, m: m, s: s});
    if (pq.size() > 0 && pq[0].due == e) begin
      set_field(pq[0].h, 5, 4);
      set_field(pq[0].m, 3, 2);
      set_field(pq[0].s, 1, 0);
      void'(pq.pop_front());
    end
    n = e;
  endtask

  // Driver: one clock edge, model update, settle before sampling.
  task automatic step();
    bit r, l, rg;
    int h, m, s;
    r = rst; l = led; rg = ring; h = hour; m = minute; s = second;
    @(posedge clk);
    model_edge(r, l, rg, h, m, s);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ring = 1'b0; led = 1'b0;
    hour = 8'd0; minute = 8'd0; second = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1) begin
        failures++;
        $display("FAIL reset: got an=%b seg=%b dp=%b, expected 111111 1111111 1", an, seg, dp);
      end
    end
    rst = 1'b0;
    hour = 8'd12; minute = 8'd34; second = 8'd56;
    for (int i = 0; i < FRAME + 5; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        failures++;
        if (failures <= 20) $display("FAIL after_reset n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_scan_fixed();
    hour = 8'd12; minute = 8'd34; second = 8'd56;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        failures++;
        if (failures <= 20) $display("FAIL scan n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      // Independent spot check: hour tens slot must show a 1.
      if (an == 6'b011111) begin
        checks++;
        if (seg !== 7'b1111001) begin
          failures++;
          $display("FAIL scan_hour_tens: got seg=%b, expected 1111001", seg);
        end
      end
    end
  endtask

  task automatic test_dash();
    hour = 8'd200; minute = 8'd59; second = 8'd7;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        failures++;
        if (failures <= 20) $display("FAIL dash n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    hour = 8'd1; minute = 8'd2; second = 8'd9;
    for (int i = 0; i < FRAME + 20; i++) step();
    for (int i = 0; i < FRAME && (n % FRAME) != 40; i++) step();
    second = 8'd10;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        failures++;
        if (failures <= 20) $display("FAIL mid_frame n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_blink();
    int blanks;
    blanks = 0;
    hour = 8'd23; minute = 8'd45; second = 8'd1;
    for (int i = 0; i < SD && (n % SD) != 0; i++) step();
    ring = 1'b1;
    for (int i = 0; i < 8 * SD; i++) begin
      step();
      if (an == 6'b111111) blanks++;
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        failures++;
        if (failures <= 20) $display("FAIL blink n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    checks++;
    if (blanks != 4 * SD) begin
      failures++;
      $display("FAIL blink_count: got %0d blank cycles, expected %0d", blanks, 4 * SD);
    end
    ring = 1'b0;
    step();
    checks++;
    if (an === 6'b111111) begin
      failures++;
      $display("FAIL blink_release: got an=%b, expected a digit enabled", an);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        failures++;
        if (failures <= 20) $display("FAIL blink_after n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_led_ring();
    led = 1'b1; ring = 1'b1;
    for (int i = 0; i < 8 * SD; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        failures++;
        if (failures <= 20) $display("FAIL led_ring n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (an != 6'b111111) begin
        checks++;
        if (seg !== 7'b0000110 || dp !== 1'b1) begin
          failures++;
          $display("FAIL led_glyph: got seg=%b dp=%b, expected 0000110 1", seg, dp);
        end
      end
    end
    led = 1'b0; ring = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    hour = 8'd11; minute = 8'd22; second = 8'd33;
    for (int i = 0; i < 2 * FRAME && !(n >= FRAME && (n % FRAME) == 4); i++) step();
    rst = 1'b1;
    step();
    checks++;
    if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_conv: got an=%b seg=%b dp=%b, expected 111111 1111111 1", an, seg, dp);
    end
    rst = 1'b0;
    step();
    checks++;
    if (an !== 6'b111110 || seg !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_zero: got an=%b seg=%b, expected 111110 1000000", an, seg);
    end
    for (int i = 0; i < FRAME + 30; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        failures++;
        if (failures <= 20) $display("FAIL reset_conv_after n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) hour   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 29) == 0) minute = 8'($urandom_range(0, 120));
      if ($urandom_range(0, 9)  == 0) second = 8'($urandom_range(0, 110));
      if ($urandom_range(0, 99) == 0) led    = ~led;
      if ($urandom_range(0, 79) == 0) ring   = ~ring;
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        failures++;
        if (failures <= 20) $display("FAIL random n=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; n = 0; ring_ticks = 0;
    for (int i = 0; i < 6; i++) mdig[i] = 0;
    rst = 1'b1; ring = 1'b0; led = 1'b0;
    hour = 8'd0; minute = 8'd0; second = 8'd0;
    test_reset();
    test_scan_fixed();
    test_dash();
    test_mid_frame_change();
    test_blink();
    test_led_ring();
    test_reset_mid_conv();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_display_driver.md
CLOCK_DISPLAY_DRIVER -- requirements
Module: clock_display_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot; legal range 16..2^20.
REQ-002 SHALL have parameter BLINK_TICKS, default 250, digit-slot ticks per blink half-period; legal range 1..2^16.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port hour  input  8  binary hour value from the clock block, 0..255.
REQ-006 SHALL have port minute  input  8  binary minute value, 0..255.
REQ-007 SHALL have port second  input  8  binary second value, 0..255.
REQ-008 SHALL have port ring  input  1  alarm/timer bell; while high, the display blinks.
REQ-009 SHALL have port led  input  1  circuit-error flag; while high, "E" shows on all digits.
REQ-010 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 SHALL have port dp  output  1  decimal point, active-low, registered.
REQ-012 SHALL have port an  output  6  digit enables, active-low one-hot, registered; an[0]=second ones … an[5]=hour tens.

Function
REQ-013 SHALL run a tick counter 0..SCAN_DIV-1; tick = one-cycle pulse when the counter equals SCAN_DIV-1, then the counter wraps to 0.
REQ-014 SHALL advance digit index 0→1→…→5→0 on each tick; a frame start is a tick where the index wraps 5→0.
REQ-015 SHALL, on each frame start, snapshot hour/minute/second and enter conversion FSM state CONV from IDLE.
REQ-016 SHALL convert all three snapshots in parallel using shift-and-add-3 (double dabble), one bit per cycle: exactly 8 CONV cycles, then 1 DONE cycle, then IDLE.
REQ-017 SHALL update all six displayed BCD digits atomically in the DONE cycle, 9 cycles after the frame-start tick, with no partial-field update.
REQ-018 SHALL ignore frame starts outside IDLE; this is unreachable for SCAN_DIV>=16.
REQ-019 SHALL, for any field snapshot >99, display both of that field's digits as dash (seg=7'b0111111); fields <=99 display decimal with leading zero.
REQ-020 SHALL use encodings 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, E=0000110, blank=1111111.
REQ-021 SHALL register outputs one cycle after the digit index/data change: an=~(1<<index), seg=code(digit[index]), dp=0 on indices 2 and 4 only, else 1.
REQ-022 SHALL, while led=1, set seg=E on every digit with dp=1; led takes priority over ring and over the dash rule.
REQ-023 SHALL count ticks while ring=1 and toggle blink_phase every BLINK_TICKS ticks; while blink_phase=1, an=6'b111111.
REQ-024 SHALL clear the blink counter and blink_phase in the cycle ring=0; display resumes on the next cycle.
REQ-025 SHALL sample led and ring each cycle, not only at frame start, so their effect appears with 1-cycle latency.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, clear the tick counter, digit index, blink counter, blink_phase and all BCD digit registers to 0, set the FSM to IDLE, and set an=6'b111111, seg=7'b1111111 and dp=1.
REQ-027 SHALL abandon any conversion interrupted by reset, leaving displayed digits at 0.
REQ-028 SHALL, after reset release, show 00.00.00 until the first DONE cycle; the first tick occurs SCAN_DIV cycles after release.

Verification (SCAN_DIV=16, BLINK_TICKS=2)
REQ-029 SHALL cover: hold hour=12, minute=34, second=56 for 2 frames -> an cycles 111110…011111 every 16 clks; seg digits 6,5,4,3,2,1; dp low only with an[2] and an[4].
REQ-030 SHALL cover: hour=200, minute=59, second=7 -> hour digits dash (0111111), then 5,9,0,7.
REQ-031 SHALL cover: change second 9->10 mid-frame -> old value shown until 9 clks after the next frame start, then both second digits switch together.
REQ-032 SHALL cover: ring=1 for 8 ticks -> an=111111 during ticks 2-3 and 6-7; ring=0 -> normal scan on the next cycle.
REQ-033 SHALL cover: led=1 and ring=1 -> every enabled digit shows 0000110 with dp=1; blink still blanks an.
REQ-034 SHALL cover: rst=1 for 1 clk 4 cycles into CONV -> next edge an=111111, seg=1111111; afterwards 00.00.00 until the next DONE.
